// File: rtl/alu_control.sv
// alu_control: registers the ALU operation select decoded from the operation class and R-type function field
module alu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in1,
  input  logic [2:0] ALUOp,
  output logic [3:0] ALUcnt
);
  logic [3:0] r_sel, alucnt_d, alucnt_q;
  always_comb begin
    r_sel = 4'b0010;
    case (in1)
      6'b000000: r_sel = 4'b0010;
      6'b000001: r_sel = 4'b0110;
      6'b000010: r_sel = 4'b0000;
      6'b000011: r_sel = 4'b0001;
      6'b000100: r_sel = 4'b0111;
      6'b000101: r_sel = 4'b1100;
      6'b000110: r_sel = 4'b0011;
      6'b000111: r_sel = 4'b1000;
      default:   r_sel = 4'b0010;
    endcase
  end
  always_comb begin
    alucnt_d = 4'b0010;
    case (ALUOp)
      3'b000:  alucnt_d = r_sel;
      3'b001:  alucnt_d = 4'b0010;
      3'b010:  alucnt_d = 4'b0110;
      3'b011:  alucnt_d = 4'b0000;
      3'b100:  alucnt_d = 4'b0001;
      3'b101:  alucnt_d = 4'b0111;
      3'b110:  alucnt_d = 4'b0011;
      default: alucnt_d = 4'b0010;
    endcase
  end
  always_ff @(posedge clk) alucnt_q <= rst ? 4'b0010 : alucnt_d;
  assign ALUcnt = alucnt_q;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: scoreboard bench for alu_control
module tb_alu_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] in1 = 6'b0;
  logic [2:0] ALUOp = 3'b0;
  logic [3:0] ALUcnt;
  logic [3:0] exp_q[$];
  logic [3:0] e;
  int vectors = 0;
  int errors = 0;

  alu_control dut (.clk(clk), .rst(rst), .in1(in1), .ALUOp(ALUOp), .ALUcnt(ALUcnt));

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [2:0] op, input logic [5:0] f);
    if (op == 3'd1) return 4'b0010;
    if (op == 3'd2) return 4'b0110;
    if (op == 3'd3) return 4'b0000;
    if (op == 3'd4) return 4'b0001;
    if (op == 3'd5) return 4'b0111;
    if (op == 3'd6) return 4'b0011;
    if (op == 3'd7) return 4'b0010;
    if (f == 6'd1) return 4'b0110;
    if (f == 6'd2) return 4'b0000;
    if (f == 6'd3) return 4'b0001;
    if (f == 6'd4) return 4'b0111;
    if (f == 6'd5) return 4'b1100;
    if (f == 6'd6) return 4'b0011;
    if (f == 6'd7) return 4'b1000;
    return 4'b0010;
  endfunction

  task automatic drive(input logic r, input logic [2:0] op, input logic [5:0] f);
    rst = r;
    ALUOp = op;
    in1 = f;
    exp_q.push_back(r ? 4'b0010 : model(op, f));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 3'b000, 6'b000001);
      e = exp_q.pop_front();
      vectors++;
      if (ALUcnt !== e) begin
        errors++;
        $display("FAIL reset[%0d]: ALUcnt=%b expected %b", i, ALUcnt, e);
      end
    end
  endtask

  task automatic test_rtype;
    logic [5:0] fs[10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'b001000, 6'b111111};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 3'b000, fs[i]);
      e = exp_q.pop_front();
      vectors++;
      if (ALUcnt !== e) begin
        errors++;
        $display("FAIL rtype in1=%b: ALUcnt=%b expected %b", fs[i], ALUcnt, e);
      end
    end
  endtask

  task automatic test_class;
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 3'(i), 6'b000111);
      e = exp_q.pop_front();
      vectors++;
      if (ALUcnt !== e || ALUcnt === 4'b1000) begin
        errors++;
        $display("FAIL class ALUOp=%0d: ALUcnt=%b expected %b", i, ALUcnt, e);
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'($urandom_range(1, 7)), 6'($urandom));
      e = exp_q.pop_front();
      vectors++;
      if (ALUcnt !== e) begin
        errors++;
        $display("FAIL class_rand ALUOp=%b in1=%b: ALUcnt=%b expected %b", ALUOp, in1, ALUcnt, e);
      end
    end
  endtask

  task automatic test_latency;
    drive(1'b0, 3'b001, 6'b000000);
    e = exp_q.pop_front();
    vectors++;
    if (ALUcnt !== e) begin
      errors++;
      $display("FAIL latency_pre: ALUcnt=%b expected %b", ALUcnt, e);
    end
    #3;
    ALUOp = 3'b010;
    #1;
    vectors++;
    if (ALUcnt !== 4'b0010) begin
      errors++;
      $display("FAIL latency_hold: ALUcnt=%b expected 0010", ALUcnt);
    end
    exp_q.push_back(model(3'b010, in1));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (ALUcnt !== e) begin
      errors++;
      $display("FAIL latency_post: ALUcnt=%b expected %b", ALUcnt, e);
    end
  endtask

  task automatic test_mid_reset;
    logic r[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(r[i], 3'b000, 6'b000101);
      e = exp_q.pop_front();
      vectors++;
      if (ALUcnt !== e) begin
        errors++;
        $display("FAIL mid_reset[%0d]: ALUcnt=%b expected %b", i, ALUcnt, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 9)));
      e = exp_q.pop_front();
      vectors++;
      if (ALUcnt !== e) begin
        errors++;
        $display("FAIL b2b[%0d] ALUOp=%b in1=%b: ALUcnt=%b expected %b", i, ALUOp, in1, ALUcnt, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_class;
    test_latency;
    test_mid_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/alu_control.md
# alu_control

Pipeline ALU-control decoder. Maps the 3-bit main-decoder operation class (`ALUOp`) and the 6-bit instruction function field (`in1`) to the 4-bit ALU operation select (`ALUcnt`). It sits between the main control unit and the execute-stage ALU. The output is registered, so it is aligned with the ID/EX pipeline boundary.

## Interface
Parameters: none.

Clocking and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in1`  input  6  instruction function field; consulted only when `ALUOp` = 000.
- `ALUOp`  input  3  operation class from the main decoder.
- `ALUcnt`  output  4  registered ALU operation select.

## Operation
ALU select encoding:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0110 SUB
- 0111 SLT
- 1000 SLL
- 1100 NOR

`ALUOp` decode:
- 000: R-type; result comes from the `in1` table below.
- 001: ADD (0010), for load/store/addi.
- 010: SUB (0110), for branch compare.
- 011: AND (0000), for andi.
- 100: OR (0001), for ori.
- 101: SLT (0111), for slti.
- 110: XOR (0011), for xori.
- 111: reserved; produces ADD (0010).

R-type `in1` table (all 6 bits compared; there are no don't-cares):
- 000000 → 0010 (ADD)
- 000001 → 0110 (SUB)
- 000010 → 0000 (AND)
- 000011 → 0001 (OR)
- 000100 → 0111 (SLT)
- 000101 → 1100 (NOR)
- 000110 → 0011 (XOR)
- 000111 → 1000 (SLL)
- Any other value (001000–111111) → 0010 (ADD). No error flag is raised.

Other rules:
- When `ALUOp` ≠ 000, `in1` is ignored completely; any `in1` value gives the same result.
- Decode is purely combinational from the current inputs. There is no other internal state besides the output register.

## Timing
- On each rising `clk` with `rst` = 1: `ALUcnt` ← 0010. Reset overrides the inputs.
- On each rising `clk` with `rst` = 0: `ALUcnt` ← decode(`ALUOp`, `in1`) sampled at that edge.
- Latency is exactly 1 cycle from input change to output. Input changes between edges have no effect on `ALUcnt`.
- Reset asserted mid-stream: `ALUcnt` becomes 0010 at the next edge. At the first edge after `rst` deasserts, `ALUcnt` takes the decode of the inputs present at that edge.
- `ALUcnt` is undefined only before the first clock edge. Benches must apply reset for at least 1 cycle.
- There is no handshake and no stall input; a new decode is produced every cycle.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `ALUOp` = 000 and `in1` = 000001 → `ALUcnt` = 0010 after each edge. Deassert `rst` → 0110 after the next edge.
- R-type sweep: `ALUOp` = 000, step `in1` through 000000..000111, one value per cycle → `ALUcnt` reads 0010, 0110, 0000, 0001, 0111, 1100, 0011, 1000, each lagging its input by 1 cycle.
- R-type unrecognized field: `ALUOp` = 000, `in1` = 001000 and then 111111 → 0010 for both.
- Class decode: `in1` = 000111 held, `ALUOp` stepped 001, 010, 011, 100, 101, 110, 111 → 0010, 0110, 0000, 0001, 0111, 0011, 0010. SLL (1000) must never appear, confirming `in1` is ignored.
- Latency and hold: change `ALUOp` from 001 to 010 midway between edges → `ALUcnt` stays 0010 until the next rising edge, then becomes 0110.
- Reset mid-operation: run with `ALUOp` = 000 and `in1` = 000101 (`ALUcnt` = 1100), pulse `rst` for 1 cycle → 0010 for that cycle, then 1100 again.
